bist_misr_checker: RTL and testbench
====================================

# bist_misr_checker

Response compactor and verdict stage downstream of the BIST controller/scan path. Consumes per-read 2-bit responses (`test_out`) with their read address (`read_a`). Folds them into a multiple-input signature register (MISR) and compares the final signature against a golden value. Produces the `bist_end`/`pass_nfail` verdict pair consumed by the top level.

## Interface
- `MISR_W`, 16, signature width (≥ 8)
- `POLY`, 16'h1021, feedback polynomial taps (bit i set → XOR feedback into bit i)
- `SEED`, 16'hFFFF, MISR value loaded on start
- `GOLDEN`, 16'h0000, expected final signature
- `N_BEATS`, 32, number of valid response beats per run (1..32)
- `clock` in 1: single clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `start` in 1: level request; a run begins on the first IDLE cycle where it is high
- `resp_valid` in 1: response beat qualifier
- `test_out` in 2: response data for the current beat
- `read_a` in 5: address associated with the current beat
- `busy` out 1: high in CAPTURE and COMPARE
- `bist_end` out 1: high in DONE
- `pass_nfail` out 1: verdict; valid only while `bist_end`=1
- `signature` out MISR_W: current MISR contents
- `seq_err` out 1: sticky address-sequence error for the current run

## Operation
- States: IDLE, CAPTURE, COMPARE, DONE.
- IDLE: `start`=1 → load MISR=SEED, beat counter=0, `seq_err`=0; go to CAPTURE. `resp_valid` is ignored in IDLE.
- CAPTURE: on each cycle with `resp_valid`=1:
  - MISR ← (MISR<<1) ^ (MISR[W-1] ? POLY : 0) ^ {read_a, 1'b0, test_out} zero-extended to MISR_W. `test_out` sits in bits [1:0], bit 2 is 0, and `read_a` sits in bits [7:3].
  - The beat counter increments.
  - The beat where counter = N_BEATS−1 is the last beat; go to COMPARE.
- Cycles with `resp_valid`=0 leave the MISR and counter unchanged. There is no timeout.
- COMPARE: one cycle; latch verdict = (MISR == GOLDEN) && !seq_err; go to DONE.
- DONE: `bist_end`=1, `pass_nfail`=latched verdict, MISR frozen. Go to IDLE when `start`=0. A `start` held high does not retrigger.
- Counter width is 6 bits; arithmetic is unsigned and the counter never wraps within a run.
- `start` deasserting during CAPTURE or COMPARE is ignored; the run completes.

## Timing
- Reset values: `busy`=0, `bist_end`=0, `pass_nfail`=0, `seq_err`=0, `signature`=SEED, state IDLE, counter 0.
- `start` sampled high at edge t → `busy`=1 after t. The first beat can be accepted at edge t+1.
- Last beat accepted at edge k → COMPARE during cycle k..k+1 → `bist_end`=1 and `pass_nfail` valid after edge k+2.
- `signature` reflects each absorbed beat one edge after acceptance.
- `pass_nfail` is forced 0 whenever `bist_end`=0.
- Reset asserted mid-run: immediate return to reset values; no verdict is produced.
- `bist_end` falls one edge after `start` is sampled low in DONE.

## Configuration
- `BIST_MISR_SEQ_CHECK_EN` defined:
  - On each accepted beat, `read_a` must equal the beat counter's low 5 bits; a mismatch sets `seq_err`, which holds until the next start.
  - The verdict includes `!seq_err`.
- Not defined:
  - `seq_err` is tied 0 and the comparator logic is absent.
  - `read_a` is still folded into the MISR.

## Test plan
- N_BEATS=1, SEED=16'h0001, GOLDEN=16'h0002: start, one beat with test_out=0 and read_a=0 → signature=16'h0002, `bist_end`=1 two edges after the beat, `pass_nfail`=1.
- Same setup with test_out=2'b01 → signature=16'h0003, `pass_nfail`=0.
- N_BEATS=32, GOLDEN from the bench model, read_a=0..31 with 3 idle gaps inserted → `pass_nfail`=1. The gaps do not alter the signature; `busy` stays high throughout.
- SEQ_CHECK_EN build: beat 5 driven with read_a=7 and GOLDEN matching the model → `seq_err`=1 and `pass_nfail`=0. Non-EN build with the model-matching GOLDEN → `pass_nfail`=1.
- Reset pulse at beat 10 → all outputs return to reset values immediately. A subsequent full run passes.
- `start` held high through DONE → no retrigger and `bist_end` stays 1. Dropping `start` → `bist_end`=0 next edge. Raising `start` again → a new run with `signature` reloaded to SEED.

Source files
------------

// File: rtl/bist_misr_checker.sv
// bist_misr_checker: folds 2-bit BIST responses and their read address into a
// MISR, then compares the final signature against a golden value and reports
// a bist_end / pass_nfail verdict.
// Optional feature macro: BIST_MISR_SEQ_CHECK_EN (read-address sequence check
// folded into the verdict; when undefined seq_err is tied low).
module bist_misr_checker #(
    parameter int unsigned        MISR_W  = 16,
    parameter logic [MISR_W-1:0]  POLY    = MISR_W'(16'h1021),
    parameter logic [MISR_W-1:0]  SEED    = MISR_W'(16'hFFFF),
    parameter logic [MISR_W-1:0]  GOLDEN  = MISR_W'(16'h0000),
    parameter int unsigned        N_BEATS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              resp_valid,
    input  logic [1:0]        test_out,
    input  logic [4:0]        read_a,
    output logic              busy,
    output logic              bist_end,
    output logic              pass_nfail,
    output logic [MISR_W-1:0] signature,
    output logic              seq_err
);

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned BEAT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [MISR_W-1:0]   misr_q, misr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                verdict_q, verdict_d;
    logic                busy_q, busy_d;
    logic                bist_end_q, bist_end_d;
    logic                pass_nfail_q, pass_nfail_d;
    logic                seq_err_q;
    logic [BEAT_W-1:0]   beat_word_c;
    logic [MISR_W-1:0]   misr_step_c;
    logic                last_beat_c;

`ifdef BIST_MISR_SEQ_CHECK_EN
    logic                seq_err_d;
`else
    assign seq_err_q = 1'b0;
`endif

    // One MISR shift with polynomial feedback and the current beat folded in
    always_comb begin
        beat_word_c = {read_a, 1'b0, test_out};
        misr_step_c = {misr_q[MISR_W-2:0], 1'b0}
                    ^ (misr_q[MISR_W-1] ? POLY : '0)
                    ^ MISR_W'(beat_word_c);
        last_beat_c = (cnt_q == CNT_W'(N_BEATS - 1));
    end

    // Next-state and next-output logic for the capture/compare sequence
    always_comb begin
        state_d   = state_q;
        misr_d    = misr_q;
        cnt_d     = cnt_q;
        verdict_d = verdict_q;
`ifdef BIST_MISR_SEQ_CHECK_EN
        seq_err_d = seq_err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CAPTURE;
                    misr_d    = SEED;
                    cnt_d     = '0;
                    verdict_d = 1'b0;
`ifdef BIST_MISR_SEQ_CHECK_EN
                    seq_err_d = 1'b0;
`endif
                end
            end
            S_CAPTURE: begin
                if (resp_valid) begin
                    misr_d = misr_step_c;
                    cnt_d  = cnt_q + CNT_W'(1);
`ifdef BIST_MISR_SEQ_CHECK_EN
                    if (read_a != cnt_q[4:0]) begin
                        seq_err_d = 1'b1;
                    end
`endif
                    if (last_beat_c) begin
                        state_d = S_COMPARE;
                    end
                end
            end
            S_COMPARE: begin
                verdict_d = (misr_q == GOLDEN) && !seq_err_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                // A held start must be released before another run can begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d       = (state_d == S_CAPTURE) || (state_d == S_COMPARE);
        bist_end_d   = (state_q == S_DONE);
        pass_nfail_d = (state_q == S_DONE) && verdict_q;
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            misr_q       <= SEED;
            cnt_q        <= '0;
            verdict_q    <= 1'b0;
            busy_q       <= 1'b0;
            bist_end_q   <= 1'b0;
            pass_nfail_q <= 1'b0;
`ifdef BIST_MISR_SEQ_CHECK_EN
            seq_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            misr_q       <= misr_d;
            cnt_q        <= cnt_d;
            verdict_q    <= verdict_d;
            busy_q       <= busy_d;
            bist_end_q   <= bist_end_d;
            pass_nfail_q <= pass_nfail_d;
`ifdef BIST_MISR_SEQ_CHECK_EN
            seq_err_q    <= seq_err_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign bist_end   = bist_end_q;
    assign pass_nfail = pass_nfail_q;
    assign signature  = misr_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_bist_misr_checker.sv
// Directed bench for bist_misr_checker: a single-beat instance with
// hand-computed signatures and a 32-beat default instance checked against a
// small MISR model.
module tb_bist_misr_checker;

    logic        clock;
    logic        reset;
    logic        start_a, start_b;
    logic        resp_valid;
    logic [1:0]  test_out;
    logic [4:0]  read_a;

    logic        busy_a, bist_end_a, pass_a, seq_err_a;
    logic [15:0] sig_a;
    logic        busy_b, bist_end_b, pass_b, seq_err_b;
    logic [15:0] sig_b;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [15:0] misr_next(input logic [15:0] m,
                                              input logic [4:0] a,
                                              input logic [1:0] t);
        logic [15:0] r;
        r = {m[14:0], 1'b0};
        if (m[15]) r = r ^ 16'h1021;
        r = r ^ {8'h00, a, 1'b0, t};
        return r;
    endfunction

    function automatic logic [15:0] model_run(input int bad_beat, input logic [4:0] bad_a);
        logic [15:0] m;
        logic [4:0]  a;
        m = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            a = (i == bad_beat) ? bad_a : 5'(i);
            m = misr_next(m, a, 2'(i));
        end
        return m;
    endfunction

    localparam logic [15:0] GOLDEN_B = model_run(-1, 5'd0);

`ifdef BIST_MISR_SEQ_CHECK_EN
    localparam logic SEQ_EXP = 1'b1;
`else
    localparam logic SEQ_EXP = 1'b0;
`endif

    bist_misr_checker #(
        .MISR_W (16), .POLY(16'h1021), .SEED(16'h0001), .GOLDEN(16'h0002), .N_BEATS(1)
    ) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .resp_valid(resp_valid),
        .test_out(test_out), .read_a(read_a), .busy(busy_a), .bist_end(bist_end_a),
        .pass_nfail(pass_a), .signature(sig_a), .seq_err(seq_err_a)
    );

    bist_misr_checker #(
        .MISR_W (16), .POLY(16'h1021), .SEED(16'hFFFF), .GOLDEN(GOLDEN_B), .N_BEATS(32)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .resp_valid(resp_valid),
        .test_out(test_out), .read_a(read_a), .busy(busy_b), .bist_end(bist_end_b),
        .pass_nfail(pass_b), .signature(sig_b), .seq_err(seq_err_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_beat(input logic [4:0] a, input logic [1:0] t);
        resp_valid = 1'b1;
        read_a     = a;
        test_out   = t;
        tick();
        resp_valid = 1'b0;
    endtask

    logic [15:0] m;
    logic [4:0]  a;

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        resp_valid = 1'b0; test_out = 2'd0; read_a = 5'd0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy",     32'(busy_b),     32'd0);
        check("rst_bist_end", 32'(bist_end_b), 32'd0);
        check("rst_pass",     32'(pass_b),     32'd0);
        check("rst_seq_err",  32'(seq_err_b),  32'd0);
        check("rst_sig_b",    32'(sig_b),      32'h0000_FFFF);
        check("rst_sig_a",    32'(sig_a),      32'h0000_0001);
        reset = 1'b0;
        tick();

        // Single-beat runs with hand-computed signatures
        for (int r = 0; r < 2; r++) begin
            start_a = 1'b1;
            tick();
            check("a_busy", 32'(busy_a), 32'd1);
            start_a = 1'b0;
            do_beat(5'd0, 2'(r));
            check("a_sig", 32'(sig_a), (r == 0) ? 32'h2 : 32'h3);
            check("a_end_k", 32'(bist_end_a), 32'd0);
            tick();
            check("a_end_k1", 32'(bist_end_a), 32'd0);
            tick();
            check("a_end_k2", 32'(bist_end_a), 32'd1);
            check("a_pass", 32'(pass_a), (r == 0) ? 32'd1 : 32'd0);
            tick();
            check("a_end_low", 32'(bist_end_a), 32'd0);
            check("a_pass_low", 32'(pass_a), 32'd0);
        end

        // Full 32-beat run with idle gaps and start held through DONE
        start_b = 1'b1;
        tick();
        check("b_busy_start", 32'(busy_b), 32'd1);
        check("b_sig_seed", 32'(sig_b), 32'h0000_FFFF);
        m = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (i == 3 || i == 10 || i == 20) begin
                tick();
                check("b_gap_busy", 32'(busy_b), 32'd1);
                check("b_gap_sig", 32'(sig_b), 32'(m));
            end
            do_beat(5'(i), 2'(i));
            m = misr_next(m, 5'(i), 2'(i));
            if (i == 0) check("b_sig_beat0", 32'(sig_b), 32'h0000_EFDF);
            if (i == 1) check("b_sig_beat1", 32'(sig_b), 32'h0000_CF96);
        end
        tick();
        tick();
        check("b_end", 32'(bist_end_b), 32'd1);
        check("b_pass", 32'(pass_b), 32'd1);
        check("b_sig_final", 32'(sig_b), 32'(GOLDEN_B));
        repeat (3) tick();
        check("b_hold_end", 32'(bist_end_b), 32'd1);
        check("b_hold_nobusy", 32'(busy_b), 32'd0);
        start_b = 1'b0;
        tick();
        tick();
        check("b_drop_end", 32'(bist_end_b), 32'd0);
        check("b_drop_pass", 32'(pass_b), 32'd0);
        start_b = 1'b1;
        tick();
        check("b_rerun_busy", 32'(busy_b), 32'd1);
        check("b_rerun_seed", 32'(sig_b), 32'h0000_FFFF);
        start_b = 1'b0;

        // Same run continues with beat 5 carrying a wrong address
        for (int i = 0; i < 32; i++) begin
            a = (i == 5) ? 5'd7 : 5'(i);
            do_beat(a, 2'(i));
            if (i == 5) check("c_seq_err_beat5", 32'(seq_err_b), 32'(SEQ_EXP));
        end
        tick();
        tick();
        check("c_end", 32'(bist_end_b), 32'd1);
        check("c_pass", 32'(pass_b), 32'd0);
        check("c_sig", 32'(sig_b), 32'(model_run(5, 5'd7)));
        check("c_seq_err_done", 32'(seq_err_b), 32'(SEQ_EXP));
        tick();
        tick();

        // Reset pulse in the middle of a run, then a clean run
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 10; i++) do_beat(5'(i), 2'(i));
        reset = 1'b1;
        #1;
        check("r_busy", 32'(busy_b), 32'd0);
        check("r_end", 32'(bist_end_b), 32'd0);
        check("r_pass", 32'(pass_b), 32'd0);
        check("r_seq_err", 32'(seq_err_b), 32'd0);
        check("r_sig", 32'(sig_b), 32'h0000_FFFF);
        tick();
        reset = 1'b0;
        tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 32; i++) do_beat(5'(i), 2'(i));
        tick();
        tick();
        check("r2_end", 32'(bist_end_b), 32'd1);
        check("r2_pass", 32'(pass_b), 32'd1);
        check("r2_seq_err", 32'(seq_err_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
